// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC RAM read streamer.
// Holds the FSM encoding, the RAM read latency and the output FIFO depth.
// The occupancy counter width is derived here so every user agrees on it.
package ldpc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ldpc_rd_fifo.sv
// Small output FIFO holding words returned by the RAM until the stream takes them.
// Latency: a pushed word is visible on head_dat the cycle after the push edge.
// Backpressure: the producer must never push when full; pops with the FIFO empty are ignored.
module ldpc_rd_fifo
   import ldpc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic             head_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign head_vld = (count != '0);
   assign head_dat = mem[rd_ptr];
   assign do_push  = push_vld && (count != FULL_CNT);
   assign do_pop   = pop_rdy && head_vld;

   // Storage array: written at the write pointer, never reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ldpc_ram_rd_stream.sv
// Reads a burst of len words from a RAM starting at base_addr and streams them out.
// Latency: first m_valid 3 cycles after start, then one word per cycle while m_ready is high.
// Backpressure: reads are issued only while in-flight plus buffered words stay below the FIFO depth.
module ldpc_ram_rd_stream
   import ldpc_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LOG2DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LOG2DEPTH-1:0] base_addr,
   input  logic [LOG2DEPTH:0]   len,
   output logic                 busy,
   output logic                 done,
   output logic [LOG2DEPTH-1:0] rdaddr,
   input  logic [WIDTH-1:0]     ram_dout,
   output logic [WIDTH-1:0]     m_data,
   output logic                 m_valid,
   input  logic                 m_ready
);

   localparam logic [LOG2DEPTH:0] REM_ONE = 1;
   localparam logic [CNT_W-1:0]   CNT_ONE = 1;

   state_t             state;
   logic [LOG2DEPTH:0] remaining;    // addresses still to be issued
   logic [RD_LAT-1:0]  inflight_vld; // bit i set: a read issued i+1 edges ago is on its way back
   logic [CNT_W-1:0]   inflight_cnt;
   logic [CNT_W-1:0]   fifo_cnt;
   logic               credit_ok;
   logic               accept_issue;
   logic               issue;
   logic               issue_any;
   logic               fifo_pop;
   logic               drained;

   // The first address goes out on the accepting edge so the first word lands 3 cycles after start.
   assign accept_issue = (state == IDLE) && start && (len != '0);
   assign credit_ok    = (int'(inflight_cnt) + int'(fifo_cnt)) < FIFO_DEPTH;
   assign issue        = (state == READ) && (remaining != '0) && credit_ok;
   assign issue_any    = accept_issue || issue;
   assign fifo_pop     = m_valid && m_ready;
   // Nothing in flight and the FIFO is empty, or its last word leaves on this edge.
   assign drained      = (inflight_vld == '0) &&
                         ((fifo_cnt == '0) || ((fifo_cnt == CNT_ONE) && fifo_pop));

   // Count of reads currently travelling through the RAM pipeline.
   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight_cnt = inflight_cnt + CNT_W'(inflight_vld[i]);
      end
   end

   // In-flight tracker: shifts in sync with the RAM so its top bit marks valid ram_dout.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_vld <= '0;
      end else begin
         inflight_vld <= {inflight_vld[RD_LAT-2:0], issue_any};
      end
   end

   // Burst FSM with registered busy, done and read address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rdaddr    <= '0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len == '0) begin
                     state <= DRAIN;
                  end else begin
                     state     <= READ;
                     rdaddr    <= base_addr;
                     remaining <= len - REM_ONE;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  rdaddr    <= rdaddr + 1'b1;
                  remaining <= remaining - REM_ONE;
               end
               // A single-word burst issued its only address on the accepting edge.
               if ((remaining == '0) || (issue && (remaining == REM_ONE))) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drained) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   ldpc_rd_fifo #(
      .WIDTH(WIDTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (inflight_vld[RD_LAT-1]),
      .push_dat (ram_dout),
      .pop_rdy  (m_ready),
      .head_vld (m_valid),
      .head_dat (m_data),
      .count    (fifo_cnt)
   );

endmodule

// File: tb/tb_ldpc_ram_rd_stream.sv
// Bench for ldpc_ram_rd_stream: RAM model, queue-based reference and directed plus random bursts.
module tb_ldpc_ram_rd_stream;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] base_addr;
   logic [4:0] len;
   logic       busy;
   logic       done;
   logic [3:0] rdaddr;
   logic [3:0] ram_dout;
   logic [3:0] m_data;
   logic       m_valid;
   logic       m_ready;

   ldpc_ram_rd_stream #(.WIDTH(4), .LOG2DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .rdaddr    (rdaddr),
      .ram_dout  (ram_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic chk_en = 0;
   logic [3:0] mem [16];

   int ready_mode = 0;   // 0: hold value, 1: random, 2: toggle
   logic ready_hold = 1;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // RAM: address seen at one edge returns data sampled by the DUT two edges after issue.
   always @(posedge clk) ram_dout <= mem[rdaddr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // m_ready driver
   initial begin
      m_ready = 1;
      forever begin
         @(posedge clk); #2;
         case (ready_mode)
            0:       m_ready = ready_hold;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = ~m_ready;
         endcase
      end
   end

   // Reference model: a burst is the list of words mem[base+i]; done follows the last transfer.
   int   exp_q[$];
   logic exp_busy = 0;
   int   exp_done_cyc = -1;
   int   words_rx = 0;
   logic prev_stall = 0;
   logic [3:0] prev_data = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, exp_busy);
         check("done", done, (cyc == exp_done_cyc));
         check("fifo_occ_le4", (dut.u_fifo.count <= 4), 1);
         if (prev_stall && !rst) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
         end
         if (rst) begin
            exp_q.delete();
            exp_busy = 0;
            exp_done_cyc = -1;
            prev_stall = 0;
         end else begin
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", m_data, cyc);
               end else begin
                  int w;
                  w = exp_q.pop_front();
                  check("m_data", m_data, w);
                  words_rx++;
                  if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
               end
            end
            if (start && !exp_busy) begin
               for (int i = 0; i < int'(len); i++) exp_q.push_back(int'(mem[(int'(base_addr) + i) % 16]));
               exp_busy = 1;
               if (len == 0) exp_done_cyc = cyc + 2;
            end
            if (cyc + 1 == exp_done_cyc) exp_busy = 0;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
   end

   task automatic do_start(input logic [3:0] b, input logic [4:0] l);
      @(posedge clk); #1;
      start = 1; base_addr = b; len = l;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_done(input string name, input int budget);
      logic seen;
      seen = 0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check(name, seen, 1);
   endtask

   logic [3:0] ra [10];
   logic [3:0] md [10];
   logic       mv [10];
   logic       dn [10];
   int         rx0;
   int         cnt_a;
   int         cnt_b;
   logic [3:0] addr_mid;
   logic       found;

   initial begin
      int exp_a [4];
      rst = 1; start = 0; base_addr = 0; len = 0;
      for (int i = 0; i < 16; i++) mem[i] = 4'(i);
      repeat (2) @(posedge clk);
      chk_en = 1;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_m_valid", m_valid, 0);
      check("reset_rdaddr", rdaddr, 0);
      @(posedge clk); #1;
      rst = 0;

      // base 3, len 5, m_ready high
      ready_mode = 0; ready_hold = 1;
      do_start(4'd3, 5'd5);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         ra[k] = rdaddr; mv[k] = m_valid; md[k] = m_data; dn[k] = done;
      end
      for (int k = 1; k <= 5; k++) check("t1_rdaddr", ra[k], 2 + k);
      check("t1_no_early_valid", mv[2], 0);
      for (int k = 3; k <= 7; k++) begin
         check("t1_valid", mv[k], 1);
         check("t1_data", md[k], k);
      end
      check("t1_valid_end", mv[8], 0);
      check("t1_done_early", dn[7], 0);
      check("t1_done", dn[8], 1);
      check("t1_done_single", dn[9], 0);

      // base 14, len 4: address wrap
      exp_a = '{14, 15, 0, 1};
      do_start(4'd14, 5'd4);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         ra[k] = rdaddr; mv[k] = m_valid; md[k] = m_data; dn[k] = done;
      end
      for (int k = 1; k <= 4; k++) check("t2_rdaddr", ra[k], exp_a[k-1]);
      for (int k = 3; k <= 6; k++) check("t2_data", md[k], exp_a[k-3]);
      check("t2_done", dn[7], 1);

      // len 16 with m_ready toggling
      rx0 = words_rx;
      do_start(4'd9, 5'd16);
      ready_mode = 2;
      wait_done("t3_done_seen", 200);
      check("t3_words", words_rx - rx0, 16);
      ready_mode = 0; ready_hold = 1;

      // 20-cycle stall mid-burst
      rx0 = words_rx;
      do_start(4'd0, 5'd16);
      repeat (4) @(posedge clk);
      #1 ready_hold = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 10) addr_mid = rdaddr;
      end
      check("t4_buffered", dut.u_fifo.count, 4);
      check("t4_valid", m_valid, 1);
      check("t4_reads_stalled", rdaddr, addr_mid);
      @(posedge clk); #1 ready_hold = 1;
      wait_done("t4_done_seen", 200);
      check("t4_words", words_rx - rx0, 16);

      // len 0 with a second start while busy
      @(posedge clk); #1;
      start = 1; base_addr = 4'd5; len = 5'd0;
      @(negedge clk);
      @(posedge clk); #1;
      start = 1; base_addr = 4'd2; len = 5'd6;
      @(negedge clk);
      check("t5_busy", busy, 1);
      check("t5_done_early", done, 0);
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      check("t5_done", done, 1);
      cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (m_valid) cnt_a++;
         if (done || busy) cnt_b++;
      end
      check("t5_no_valid", cnt_a, 0);
      check("t5_second_start_ignored", cnt_b, 0);

      // reset mid-burst, with a start coinciding with reset
      do_start(4'd0, 5'd16);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (rdaddr == 4'd5) found = 1;
      end
      check("t6_addr5_seen", found, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1; start = 1; base_addr = 4'd9; len = 5'd3;
      @(posedge clk); #1;
      rst = 0; start = 0;
      @(negedge clk);
      check("t6_valid_after_rst", m_valid, 0);
      check("t6_busy_after_rst", busy, 0);
      check("t6_rdaddr_after_rst", rdaddr, 0);
      cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (m_valid) cnt_a++;
         if (done || busy) cnt_b++;
      end
      check("t6_no_stale_word", cnt_a, 0);
      check("t6_no_done_or_busy", cnt_b, 0);

      // random bursts with random memory contents and random backpressure
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      ready_mode = 1;
      for (int it = 0; it < 30; it++) begin
         do_start(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)));
         if ($urandom_range(0, 1) == 1) begin
            start = 1;
            base_addr = 4'($urandom_range(0, 15));
            len = 5'($urandom_range(0, 16));
            @(posedge clk); #1;
            start = 0;
         end
         wait_done("rand_done_seen", 400);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      ready_mode = 0; ready_hold = 1;
      repeat (5) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ldpc_ram_rd_stream.md
LDPC_RAM_RD_STREAM -- requirements
Module: ldpc_ram_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data word width, matching the RAM data width.
REQ-002 SHALL have parameter LOG2DEPTH, default 4: RAM address width.
REQ-003 SHALL have clk, input, 1: single clock; all logic is rising-edge triggered.
REQ-004 SHALL have rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have start, input, 1: one-cycle command strobe.
REQ-006 SHALL have base_addr, input, LOG2DEPTH: first RAM address of the burst.
REQ-007 SHALL have len, input, LOG2DEPTH+1: word count, 0..2**LOG2DEPTH.
REQ-008 SHALL have busy, output, 1: high from an accepted start until done.
REQ-009 SHALL have done, output, 1: one-cycle pulse at burst completion.
REQ-010 SHALL have rdaddr, output, LOG2DEPTH: RAM read address.
REQ-011 SHALL have ram_dout, input, WIDTH: RAM read data.
REQ-012 SHALL have m_data, output, WIDTH: stream data.
REQ-013 SHALL have m_valid, output, 1: stream valid.
REQ-014 SHALL have m_ready, input, 1: stream ready; a transfer occurs when m_valid and m_ready are both high on a clock edge.

Function
REQ-015 SHALL treat RAM read latency as exactly 2 cycles: an address driven on rdaddr in cycle n yields its word on ram_dout, sampled in cycle n+2.
REQ-016 SHALL use FSM states IDLE, READ and DRAIN.
REQ-017 SHALL transition IDLE->READ on start with len>0, and IDLE->DRAIN on start with len==0.
REQ-018 SHALL transition READ->DRAIN in the cycle the last address is issued.
REQ-019 SHALL transition DRAIN->IDLE when no reads are in flight, the FIFO is empty and the last word has been transferred.
REQ-020 SHALL assert done for the single cycle on which the FSM leaves DRAIN.
REQ-021 SHALL, for len==0, produce no reads and pulse done exactly 2 cycles after start.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL latch base_addr and len only on an accepted start.
REQ-024 SHALL issue address base_addr+i mod 2**LOG2DEPTH for i = 0..len-1, in order; the address wraps from 2**LOG2DEPTH-1 to 0.
REQ-025 SHALL track in-flight reads with a 2-stage valid shift register aligned to the RAM latency.
REQ-026 SHALL push each returning word into an output FIFO of depth 4.
REQ-027 SHALL issue a read in a given cycle only when (in-flight count + FIFO occupancy) < 4, so that backpressure can never overflow the FIFO.
REQ-028 SHALL, with m_ready held high, sustain one word per cycle after an initial latency of 3 cycles from start to first m_valid.
REQ-029 SHALL, when a FIFO push and pop occur in the same cycle, keep the occupancy unchanged.
REQ-030 SHALL drive m_valid = FIFO non-empty and m_data = FIFO head.
REQ-031 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-032 SHALL hold rdaddr at its last issued value while not issuing, and its value SHALL be don't-care for correctness.
REQ-033 SHALL never drive the RAM write port; the write side, including the active-low write enable, is owned elsewhere.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, set state=IDLE, busy=0, done=0, m_valid=0, FIFO empty, in-flight register cleared, rdaddr=0.
REQ-035 SHALL, on reset mid-burst, discard in-flight RAM data arriving after reset and emit no done pulse for the aborted burst.
REQ-036 SHALL ignore a start that coincides with rst=1.

Structure
REQ-037 SHALL place the FSM state encoding, the RD_LAT=2 constant and the FIFO_DEPTH=4 constant in a shared package (ldpc_pkg).
REQ-038 SHALL implement the output FIFO as sub-module ldpc_rd_fifo (depth 4, with a registered occupancy count), instantiated once.

Verification
REQ-039 SHALL verify: RAM preloaded with mem[i]=i, base=3, len=5, m_ready=1 -> rdaddr 3,4,5,6,7; m_data 3..7 on consecutive cycles; done 1 cycle after the last transfer.
REQ-040 SHALL verify: base=14, len=4 -> addresses 14,15,0,1 and data in that order.
REQ-041 SHALL verify: len=16, m_ready toggled 1-0-1-0 -> all 16 words in order, no loss or duplication, FIFO occupancy never above 4.
REQ-042 SHALL verify: m_ready=0 for 20 cycles mid-burst -> exactly 4 words buffered, reads stall, m_data stable; on release the stream resumes.
REQ-043 SHALL verify: len=0 -> no m_valid; done exactly 2 cycles after start; a second start while busy is ignored.
REQ-044 SHALL verify: rst asserted 2 cycles after issuing address 5 -> the next cycle shows m_valid=0 and busy=0; no stale word and no done afterwards.
